id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Parametrised decode stage for the 5-stage MIPS pipeline.
- Contains:
  - the register bank
  - sign/zero extension
  - branch operand forwarding and compare
  - jump/branch/JR target generation
  - a load-use and branch hazard detector
- Adds a registered ID/EX output with valid/ready handshake and a saturating stall counter.
- Sits between the IF/ID register and the EX stage; issues PC redirect and IF flush on taken control transfers.

Parameters:
- DATA_W, 32: datapath and register width.
- NREG, 32: number of architectural registers; register 0 is hardwired to zero.
- REG_AW, 5: register address width; must satisfy 2^REG_AW >= NREG.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  IF/ID holds a valid instruction.
- in_ready  out  1  decode accepts the instruction this cycle.
- inst  in  32  instruction word; rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0], target=[25:0].
- pc  in  DATA_W  PC+4 of inst.
- br_op  in  3  000 none, 001 beq, 010 bne, 011 j, 100 jr; others are treated as none.
- sext_ctrl  in  1  1 sign-extend imm, 0 zero-extend.
- uses_rt  in  1  instruction reads rt.
- wb_we, wb_addr, wb_data  in  1/REG_AW/DATA_W  writeback port.
- ex_we, ex_is_load, ex_dst  in  1/1/REG_AW  instruction currently in EX.
- mem_we, mem_is_load, mem_dst, mem_data  in  1/1/REG_AW/DATA_W  instruction in MEM and its ALU result.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX accepts.
- out_pc, out_rs_data, out_rt_data, out_imm  out  DATA_W  registered.
- out_rs, out_rt, out_rd  out  REG_AW  registered.
- redirect  out  1  taken branch/jump accepted this cycle; also the IF flush.
- redirect_pc  out  DATA_W  new fetch address.
- stall_cnt  out  CNT_W  count of hazard-stall cycles.

Behaviour:
- Reset (async, rst_n=0):
  - all register-bank entries = 0
  - out_valid = 0 and all out_* = 0
  - stall_cnt = 0
  - redirect, redirect_pc and in_ready are combinational; with in_valid=0 they are 0, 0 and 1.
  - Reset mid-transfer discards the ID/EX contents.
- Register bank:
  - Write on clk when wb_we and wb_addr != 0.
  - Reads are combinational and write-first: a same-cycle read of wb_addr returns wb_data.
  - Addresses >= NREG read 0 and ignore writes.
- Operand select (rs and rt independently):
  - If mem_we, !mem_is_load, mem_dst != 0 and mem_dst == src, use mem_data.
  - Otherwise use the register-bank read.
  - Address 0 always yields 0.
- Hazard (combinational), asserted when in_valid and any of:
  - (a) load-use: ex_we & ex_is_load & ex_dst != 0, with ex_dst == rs, or (ex_dst == rt & uses_rt).
  - (b) branch-on-EX: br_op in {beq, bne, jr}, ex_we, ex_dst != 0, ex_dst matches a compare source (rt only for beq/bne).
  - (c) branch-on-MEM-load: same as (b) using mem_we & mem_is_load & mem_dst.
- Handshake:
  - in_ready = !hazard & (!out_valid | out_ready).
  - fire = in_valid & in_ready.
  - On fire, the ID/EX register loads: pc, selected rs/rt data, extended imm, rs/rt/rd; out_valid <= 1.
  - If !fire and (out_ready or !out_valid), out_valid <= 0 (bubble).
  - Otherwise the ID/EX register holds, with contents stable while out_valid & !out_ready.
- Control transfer (only on fire):
  - beq taken when rs_sel == rt_sel; bne taken when they differ.
  - Branch target = pc + (ext_imm << 2), modulo 2^DATA_W.
  - j: redirect_pc = {pc[DATA_W-1:28], target, 2'b00}.
  - jr: redirect_pc = rs_sel.
  - redirect is high in the fire cycle only.
  - Redirect never asserts on a stalled or non-valid cycle.
- stall_cnt:
  - Increments each cycle that in_valid & hazard.
  - Saturates at 2^CNT_W - 1 (no wrap).
- A simultaneous hazard and downstream back-pressure produces a single stall cycle, counted once.

Test Plan:
- Reset, write r5=0x1234 via WB, then decode `addu r1,r5,r0` with out_ready=1 -> next cycle out_valid=1, out_rs_data=0x1234, out_rt_data=0.
- Same-cycle WB write r7=0xAA while decoding a read of r7 -> out_rs_data=0xAA. A WB write to r0 of 0xFF, then a read of r0 -> 0.
- EX holds `lw r3`, ID has `add r4,r3,r2` -> in_ready=0 for one cycle, stall_cnt=1, bubble (out_valid=0). EX then clears -> fire.
- beq r1,r2 with r1=r2=9, pc=0x100, imm=0xFFFF -> redirect=1, redirect_pc=0xFC. With r2=8 -> redirect=0. Forwarding from MEM with mem_data=9 overrides a stale bank value.
- jr r31 (r31=0x400) and j target=0x10, pc=0x80000004 -> redirect_pc=0x400 and 0x80000040 respectively.
- out_ready=0 for 3 cycles with out_valid=1 -> out_* stable and in_ready=0. Hold rst_n low for 70000 hazard cycles with CNT_W=16 is excluded; instead force 65540 hazard cycles -> stall_cnt=0xFFFF. rst_n pulse mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: register bank, operand forwarding, branch resolution,
// hazard detection and a registered ID/EX output with valid/ready handshake.
module id_stage_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    input  logic [DATA_W-1:0] pc,
    input  logic [2:0]        br_op,
    input  logic              sext_ctrl,
    input  logic              uses_rt,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_we,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              mem_we,
    input  logic              mem_is_load,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_rd,
    output logic              redirect,
    output logic [DATA_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_J    = 3'b011,
        BR_JR   = 3'b100
    } br_op_e;

    logic [DATA_W-1:0] rf_q [NREG];

    logic [REG_AW-1:0] rs_a, rt_a, rd_a;
    logic [DATA_W-1:0] imm_ext, rs_sel, rt_sel, tgt;
    logic              is_bxx, uses_br, taken;
    logic              ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic              load_use, br_ex, br_mem, hazard, fire;
    logic              unused_opcode;
    br_op_e            op_e;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q, pc_d, rsd_q, rsd_d, rtd_q, rtd_d, imm_q, imm_d;
    logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    function automatic logic addr_ok(input logic [REG_AW-1:0] a);
        return {{(32-REG_AW){1'b0}}, a} < NREG;
    endfunction

    // Write-first read: a same-cycle writeback to the address bypasses the bank.
    function automatic logic [DATA_W-1:0] rf_read(input logic [REG_AW-1:0] a);
        if (a == '0 || !addr_ok(a)) return '0;
        if (wb_we && wb_addr == a) return wb_data;
        return rf_q[a];
    endfunction

    function automatic logic [DATA_W-1:0] opnd_sel(input logic [REG_AW-1:0] a);
        if (mem_we && !mem_is_load && mem_dst != '0 && mem_dst == a) return mem_data;
        return rf_read(a);
    endfunction

    assign unused_opcode = &{1'b0, inst[31:26]};
    assign op_e = br_op_e'(br_op);
    assign rs_a = REG_AW'(inst[25:21]);
    assign rt_a = REG_AW'(inst[20:16]);
    assign rd_a = REG_AW'(inst[15:11]);

    assign imm_ext = sext_ctrl ? {{(DATA_W-16){inst[15]}}, inst[15:0]}
                               : {{(DATA_W-16){1'b0}}, inst[15:0]};
    assign rs_sel  = opnd_sel(rs_a);
    assign rt_sel  = opnd_sel(rt_a);

    assign is_bxx     = (op_e == BR_BEQ) || (op_e == BR_BNE);
    assign uses_br    = is_bxx || (op_e == BR_JR);
    assign ex_hit_rs  = (ex_dst != '0) && (ex_dst == rs_a);
    assign ex_hit_rt  = (ex_dst != '0) && (ex_dst == rt_a);
    assign mem_hit_rs = (mem_dst != '0) && (mem_dst == rs_a);
    assign mem_hit_rt = (mem_dst != '0) && (mem_dst == rt_a);

    assign load_use = ex_we && ex_is_load && (ex_hit_rs || (ex_hit_rt && uses_rt));
    assign br_ex    = uses_br && ex_we && (ex_hit_rs || (ex_hit_rt && is_bxx));
    assign br_mem   = uses_br && mem_we && mem_is_load
                      && (mem_hit_rs || (mem_hit_rt && is_bxx));
    assign hazard   = in_valid && (load_use || br_ex || br_mem);

    assign in_ready = !hazard && (!valid_q || out_ready);
    assign fire     = in_valid && in_ready;

    always_comb begin
        taken = 1'b0;
        tgt   = '0;
        case (op_e)
            BR_BEQ: begin
                taken = (rs_sel == rt_sel);
                tgt   = pc + (imm_ext << 2);
            end
            BR_BNE: begin
                taken = (rs_sel != rt_sel);
                tgt   = pc + (imm_ext << 2);
            end
            BR_J: begin
                taken = 1'b1;
                tgt   = {pc[DATA_W-1:28], inst[25:0], 2'b00};
            end
            BR_JR: begin
                taken = 1'b1;
                tgt   = rs_sel;
            end
            default: ;
        endcase
    end

    assign redirect    = fire && taken;
    assign redirect_pc = redirect ? tgt : '0;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rsd_d   = rsd_q;
        rtd_d   = rtd_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        stall_d = stall_q;
        if (fire) begin
            valid_d = 1'b1;
            pc_d    = pc;
            rsd_d   = rs_sel;
            rtd_d   = rt_sel;
            imm_d   = imm_ext;
            rs_d    = rs_a;
            rt_d    = rt_a;
            rd_d    = rd_a;
        end else if (out_ready || !valid_q) begin
            valid_d = 1'b0;
        end
        if (hazard && stall_q != '1) stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb_we && wb_addr != '0 && addr_ok(wb_addr)) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rsd_q   <= '0;
            rtd_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rsd_q   <= rsd_d;
            rtd_q   <= rtd_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            stall_q <= stall_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_rs_data = rsd_q;
    assign out_rt_data = rtd_q;
    assign out_imm     = imm_q;
    assign out_rs      = rs_q;
    assign out_rt      = rt_q;
    assign out_rd      = rd_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed and randomized checks of id_stage_pipe against an in-bench model.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] inst, pc;
    logic [2:0]  br_op;
    logic        sext_ctrl, uses_rt;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_we, ex_is_load;
    logic [4:0]  ex_dst;
    logic        mem_we, mem_is_load;
    logic [4:0]  mem_dst;
    logic [31:0] mem_data;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_rs_data, out_rt_data, out_imm;
    logic [4:0]  out_rs, out_rt, out_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_W(32), .NREG(32), .REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .br_op(br_op), .sext_ctrl(sext_ctrl), .uses_rt(uses_rt),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_dst(ex_dst),
        .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_dst(mem_dst), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
        .out_imm(out_imm), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall_cnt(stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m_rf [32];
    logic        m_valid;
    logic [31:0] m_pc, m_rsd, m_rtd, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    int          m_stall;
    bit          e_haz, e_ready, e_fire, e_redir;
    logic [31:0] e_rpc;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'h0;
        if (wb_we && int'(wb_addr) == a) return wb_data;
        return m_rf[a];
    endfunction

    function automatic logic [31:0] m_opnd(input int a);
        if (a != 0 && mem_we && !mem_is_load && int'(mem_dst) == a) return mem_data;
        return m_read(a);
    endfunction

    function automatic logic [31:0] m_ext();
        int v = int'(inst[15:0]);
        if (sext_ctrl && v >= 32768) v = v - 65536;
        return 32'(v);
    endfunction

    function automatic bit m_hazard();
        int ld_src[$];
        int br_src[$];
        int rs = int'(inst[25:21]);
        int rt = int'(inst[20:16]);
        if (!in_valid) return 1'b0;
        ld_src.push_back(rs);
        if (uses_rt) ld_src.push_back(rt);
        if (br_op == 3'd1 || br_op == 3'd2) begin
            br_src.push_back(rs);
            br_src.push_back(rt);
        end else if (br_op == 3'd4) begin
            br_src.push_back(rs);
        end
        foreach (ld_src[i])
            if (ex_we && ex_is_load && ex_dst != 0 && int'(ex_dst) == ld_src[i]) return 1'b1;
        foreach (br_src[i]) begin
            if (ex_we && ex_dst != 0 && int'(ex_dst) == br_src[i]) return 1'b1;
            if (mem_we && mem_is_load && mem_dst != 0 && int'(mem_dst) == br_src[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        foreach (m_rf[i]) m_rf[i] = 32'h0;
        m_valid = 0; m_pc = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
        m_rs = 0; m_rt = 0; m_rd = 0; m_stall = 0;
    endtask

    task automatic idle();
        in_valid = 0; inst = 0; pc = 0; br_op = 0; sext_ctrl = 0; uses_rt = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0; ex_we = 0; ex_is_load = 0; ex_dst = 0;
        mem_we = 0; mem_is_load = 0; mem_dst = 0; mem_data = 0; out_ready = 1;
    endtask

    task automatic check_comb();
        logic [31:0] a, b;
        bit taken;
        logic [31:0] tgt;
        @(negedge clk);
        e_haz   = m_hazard();
        e_ready = !e_haz && (!m_valid || out_ready);
        e_fire  = in_valid && e_ready;
        a = m_opnd(int'(inst[25:21]));
        b = m_opnd(int'(inst[20:16]));
        taken = 0; tgt = 0;
        case (br_op)
            3'd1: begin taken = (a == b); tgt = pc + m_ext() * 4; end
            3'd2: begin taken = (a != b); tgt = pc + m_ext() * 4; end
            3'd3: begin taken = 1; tgt = (pc & 32'hF000_0000) | (32'(inst[25:0]) * 4); end
            3'd4: begin taken = 1; tgt = a; end
            default: ;
        endcase
        e_redir = e_fire && taken;
        e_rpc   = e_redir ? tgt : 32'h0;
        check("in_ready", 192'(in_ready), 192'(e_ready));
        check("redirect", 192'(redirect), 192'(e_redir));
        check("redirect_pc", 192'(redirect_pc), 192'(e_rpc));
    endtask

    task automatic commit();
        @(posedge clk);
        if (e_fire) begin
            m_valid = 1;
            m_pc  = pc;
            m_rsd = m_opnd(int'(inst[25:21]));
            m_rtd = m_opnd(int'(inst[20:16]));
            m_imm = m_ext();
            m_rs = inst[25:21]; m_rt = inst[20:16]; m_rd = inst[15:11];
        end else if (out_ready || !m_valid) begin
            m_valid = 0;
        end
        if (e_haz && m_stall < 65535) m_stall++;
        if (wb_we && wb_addr != 0) m_rf[wb_addr] = wb_data;
        #1;
        check("out_valid", 192'(out_valid), 192'(m_valid));
        check("stall_cnt", 192'(stall_cnt), 192'(m_stall));
        if (m_valid)
            check("idex_bundle",
                  192'({out_pc, out_rs_data, out_rt_data, out_imm, out_rs, out_rt, out_rd}),
                  192'({m_pc, m_rsd, m_rtd, m_imm, m_rs, m_rt, m_rd}));
    endtask

    task automatic cycle();
        check_comb();
        commit();
    endtask

    task automatic wb(input int a, input logic [31:0] d);
        idle();
        wb_we = 1; wb_addr = 5'(a); wb_data = d;
        cycle();
        wb_we = 0;
    endtask

    task automatic set_inst(input int op, input int rs, input int rt, input int rd,
                            input logic [15:0] imm);
        inst = {6'h0, 5'(rs), 5'(rt), 5'(rd), imm[10:0]};
        inst[15:0] = imm;
        inst[15:11] = (op == 0) ? 5'(rd) : imm[15:11];
        br_op = 3'(op);
        in_valid = 1;
        uses_rt = 1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rand_reg();
        int k = int'($urandom_range(0, 4));
        return (k == 4) ? 5'd31 : 5'(k);
    endfunction

    initial begin
        idle();
        rst_n = 0;
        model_reset();
        #2;
        check("rst_out_valid", 192'(out_valid), 192'(0));
        check("rst_outs", 192'({out_pc, out_rs_data, out_rt_data, out_imm, out_rs, out_rt, out_rd}), 192'(0));
        check("rst_stall", 192'(stall_cnt), 192'(0));
        check("rst_comb", 192'({redirect, redirect_pc, in_ready}), 192'({1'b0, 32'h0, 1'b1}));
        release_reset();

        wb(5, 32'h1234);
        idle(); set_inst(0, 5, 0, 1, 16'h0000);
        cycle();
        check("addu_rs", 192'(out_rs_data), 192'(32'h1234));
        check("addu_rt", 192'(out_rt_data), 192'(0));

        idle(); set_inst(0, 7, 0, 2, 16'h0);
        wb_we = 1; wb_addr = 7; wb_data = 32'hAA;
        cycle();
        check("wb_bypass", 192'(out_rs_data), 192'(32'hAA));
        wb(0, 32'hFF);
        idle(); set_inst(0, 0, 0, 3, 16'h0);
        cycle();
        check("r0_zero", 192'(out_rs_data), 192'(0));

        idle(); set_inst(0, 3, 2, 4, 16'h0);
        ex_we = 1; ex_is_load = 1; ex_dst = 3;
        check_comb();
        check("loaduse_ready", 192'(in_ready), 192'(0));
        commit();
        check("loaduse_bubble", 192'(out_valid), 192'(0));
        check("loaduse_stall", 192'(stall_cnt), 192'(1));
        ex_we = 0; ex_is_load = 0; ex_dst = 0;
        cycle();

        wb(1, 9); wb(2, 9);
        idle(); set_inst(1, 1, 2, 0, 16'hFFFF); sext_ctrl = 1; pc = 32'h100;
        check_comb();
        check("beq_taken", 192'({redirect, redirect_pc}), 192'({1'b1, 32'hFC}));
        commit();
        wb(2, 8);
        idle(); set_inst(1, 1, 2, 0, 16'hFFFF); sext_ctrl = 1; pc = 32'h100;
        check_comb();
        check("beq_not_taken", 192'(redirect), 192'(0));
        commit();
        mem_we = 1; mem_dst = 2; mem_data = 9;
        check_comb();
        check("beq_fwd", 192'({redirect, redirect_pc}), 192'({1'b1, 32'hFC}));
        commit();

        wb(31, 32'h400);
        idle(); set_inst(4, 31, 0, 0, 16'h0); uses_rt = 0;
        check_comb();
        check("jr_target", 192'(redirect_pc), 192'(32'h400));
        commit();
        idle(); inst = {6'h02, 26'h10}; br_op = 3; in_valid = 1; pc = 32'h8000_0004;
        check_comb();
        check("j_target", 192'(redirect_pc), 192'(32'h8000_0040));
        commit();

        idle(); set_inst(0, 1, 2, 5, 16'h0); out_ready = 0; pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            check_comb();
            check("bp_ready", 192'(in_ready), 192'(0));
            commit();
        end
        out_ready = 1;
        cycle();

        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            inst        = {$urandom_range(0, 63), rand_reg(), rand_reg(), rand_reg(), 11'($urandom)};
            inst[31:26] = 6'($urandom);
            pc          = $urandom;
            br_op       = 3'($urandom);
            sext_ctrl   = 1'($urandom);
            uses_rt     = 1'($urandom);
            wb_we       = 1'($urandom);
            wb_addr     = rand_reg();
            wb_data     = $urandom;
            ex_we       = ($urandom_range(0, 3) == 0);
            ex_is_load  = 1'($urandom);
            ex_dst      = rand_reg();
            mem_we      = 1'($urandom);
            mem_is_load = 1'($urandom);
            mem_dst     = rand_reg();
            mem_data    = $urandom;
            out_ready   = ($urandom_range(0, 9) < 7);
            cycle();
        end

        idle();
        rst_n = 0;
        model_reset();
        #2;
        release_reset();
        set_inst(0, 3, 0, 1, 16'h0);
        ex_we = 1; ex_is_load = 1; ex_dst = 3;
        repeat (65540) @(posedge clk);
        #1;
        m_stall = 65535;
        check("stall_sat", 192'(stall_cnt), 192'(m_stall));
        check("stall_sat_bubble", 192'(out_valid), 192'(0));

        rst_n = 0;
        #1;
        check("midreset_regs", 192'({out_valid, stall_cnt}), 192'(0));
        check("midreset_outs", 192'({out_pc, out_rs_data, out_rt_data, out_imm, out_rs, out_rt, out_rd}), 192'(0));
        check("midreset_redirect", 192'({redirect, redirect_pc}), 192'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
